// File: rtl/stack_seq.sv
`default_nettype none
// ============================================================================
// Module      : stack_seq
// Description : Instruction sequencer in front of the three-register-plus-
//               memory data stack. It accepts one stack instruction per
//               valid/ready handshake and drives the stack's cmd/in inputs.
//               It reads top-of-stack s0 back so it can run two-cycle ALU
//               operations. It tracks depth and raises sticky
//               overflow/underflow flags, so an illegal instruction never
//               reaches the stack.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_seq #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int MAXD = 256
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [3:0]    op,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] s0,
    output logic [2:0]    cmd,
    output logic [DW-1:0] in,
    output logic [AW+1:0] depth,
    output logic          busy,
    output logic          ovf,
    output logic          unf,
    input  logic          err_clr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_op_nop  = 4'd0;
    localparam logic [3:0] c_op_lit  = 4'd1;
    localparam logic [3:0] c_op_dup  = 4'd2;
    localparam logic [3:0] c_op_drop = 4'd3;
    localparam logic [3:0] c_op_add  = 4'd4;
    localparam logic [3:0] c_op_sub  = 4'd5;
    localparam logic [3:0] c_op_and  = 4'd6;
    localparam logic [3:0] c_op_or   = 4'd7;
    localparam logic [3:0] c_op_xor  = 4'd8;
    localparam logic [3:0] c_op_not  = 4'd9;

    // Stack command encodings: {update, push, pop}
    localparam logic [2:0] c_cmd_none = 3'b000;
    localparam logic [2:0] c_cmd_lit  = 3'b110;
    localparam logic [2:0] c_cmd_dup  = 3'b010;
    localparam logic [2:0] c_cmd_pop  = 3'b001;
    localparam logic [2:0] c_cmd_upd  = 3'b100;

    localparam logic [AW+1:0] c_maxd = (AW+2)'(MAXD);
    localparam logic [AW+1:0] c_zero = '0;
    localparam logic [AW+1:0] c_one  = (AW+2)'(1);
    localparam logic [AW+1:0] c_two  = (AW+2)'(2);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BIN2 = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW+1:0]   r_depth;
    logic [AW+1:0]   w_depth_nxt;
    logic [DW-1:0]   r_t;
    logic [3:0]      r_opr;
    logic            r_ovf;
    logic            r_unf;
    logic            w_set_ovf;
    logic            w_set_unf;
    logic            w_latch;
    logic            w_accept;
    logic            w_is_bin;
    logic [DW-1:0]   w_alu;

    // ------------------------------------------------------------------------
    // Handshake and status outputs
    // ------------------------------------------------------------------------
    // Reset is folded into accept so nothing reaches the stack while
    // reset_n is low, even if op_valid is high.
    assign op_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_BIN2);
    assign w_accept = op_valid & op_ready & reset_n;
    assign depth    = r_depth;
    assign ovf      = r_ovf;
    assign unf      = r_unf;
    assign w_is_bin = (op >= c_op_add) && (op <= c_op_xor);

    // ALU result for the second cycle of a binary op: s0 is NOS, r_t is old TOS
    always_comb begin
        w_alu = '0;
        case (r_opr)
            c_op_add: w_alu = s0 + r_t;
            c_op_sub: w_alu = s0 - r_t;
            c_op_and: w_alu = s0 & r_t;
            c_op_or:  w_alu = s0 | r_t;
            c_op_xor: w_alu = s0 ^ r_t;
            default:  w_alu = '0;
        endcase
    end

    // Next-state, stack command, depth update and error detection
    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        cmd         = c_cmd_none;
        in          = '0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_latch     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (op == c_op_lit) begin
                        if (r_depth == c_maxd) begin
                            w_set_ovf = 1'b1;
                        end else begin
                            cmd         = c_cmd_lit;
                            in          = imm;
                            w_depth_nxt = r_depth + c_one;
                        end
                    end else if (op == c_op_dup) begin
                        if (r_depth == c_maxd) begin
                            w_set_ovf = 1'b1;
                        end else begin
                            cmd         = c_cmd_dup;
                            w_depth_nxt = r_depth + c_one;
                        end
                    end else if (op == c_op_drop) begin
                        if (r_depth == c_zero) begin
                            w_set_unf = 1'b1;
                        end else begin
                            cmd         = c_cmd_pop;
                            w_depth_nxt = r_depth - c_one;
                        end
                    end else if (w_is_bin) begin
                        // Pop TOS into r_t now; the result overwrites NOS
                        // in the following BIN2 cycle.
                        if (r_depth < c_two) begin
                            w_set_unf = 1'b1;
                        end else begin
                            cmd         = c_cmd_pop;
                            w_depth_nxt = r_depth - c_one;
                            w_latch     = 1'b1;
                            w_state_nxt = S_BIN2;
                        end
                    end else if (op == c_op_not) begin
                        if (r_depth == c_zero) begin
                            w_set_unf = 1'b1;
                        end else begin
                            cmd = c_cmd_upd;
                            in  = ~s0;
                        end
                    end
                    // c_op_nop and opcodes 10..15 fall through as no-ops
                end
            end
            S_BIN2: begin
                cmd         = c_cmd_upd;
                in          = w_alu;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, depth counter and binary-op operand latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_depth <= '0;
            r_t     <= '0;
            r_opr   <= c_op_nop;
        end else begin
            r_state <= w_state_nxt;
            r_depth <= w_depth_nxt;
            if (w_latch) begin
                r_t   <= s0;
                r_opr <= op;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_set_ovf | (r_ovf & ~err_clr);
            r_unf <= w_set_unf | (r_unf & ~err_clr);
        end
    end

endmodule
`default_nettype wire

// File: doc/stack_seq.md
# stack_seq

Instruction sequencer that sits directly upstream of the three-register-plus-memory data stack. It accepts one stack instruction at a time over a valid/ready handshake and drives the stack's `cmd` and `in` inputs. It reads the stack's top-of-stack `s0` back to perform ALU operations. It also tracks stack depth and raises sticky overflow and underflow flags, so illegal instructions never reach the stack.

## Interface
- `AW`, 8: stack memory address width, matching the stack instance.
- `DW`, 16: data width.
- `MAXD`, 256: maximum legal depth in entries, at most 2**AW + 3.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `op_valid`  in  1: instruction valid.
- `op_ready`  out  1: sequencer can accept an instruction.
- `op`  in  4: opcode.
- `imm`  in  DW: immediate for LIT.
- `s0`  in  DW: top of stack from the stack block.
- `cmd`  out  3: to stack; [2]=update (s0<=in), [1]=push, [0]=pop.
- `in`  out  DW: to stack data input.
- `depth`  out  AW+2: current entry count.
- `busy`  out  1: high while in state BIN2.
- `ovf`, `unf`  out  1 each: sticky overflow and underflow flags.
- `err_clr`  in  1: clears `ovf` and `unf`.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LIT: cmd=110, in=imm, depth+1.
  - 2 DUP: cmd=010, depth+1.
  - 3 DROP: cmd=001, depth-1.
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR: binary, depth-1.
  - 9 NOT: cmd=100, in=~s0, depth unchanged.
  - 10–15: illegal; treated as NOP with no flag set.
- Accept occurs when op_valid and op_ready are both high. Pop and push are never asserted together.
- FSM states:
  - IDLE: op_ready=1.
    - Single-cycle ops drive `cmd`/`in` combinationally in the accept cycle and stay in IDLE.
    - A legal binary op latches t<=s0 and opr<=op, drives cmd=001 (pop), and goes to BIN2.
  - BIN2: op_ready=0, busy=1.
    - s0 now holds the former next-of-stack (NOS).
    - Drives cmd=100, in=f(s0, t), and returns to IDLE unconditionally.
- ALU results are modulo 2**DW. SUB = NOS − TOS = s0 − t. The other ops are bitwise or sum on (s0, t).
- Guards, evaluated at accept:
  - LIT or DUP with depth==MAXD: not executed, cmd=000, ovf<=1.
  - DROP or NOT with depth==0: not executed, unf<=1.
  - Binary op with depth<2: not executed, unf<=1.
  - A blocked instruction is still consumed (handshake completes) and depth is unchanged.
- Flags:
  - `err_clr` clears both flags.
  - If `err_clr` coincides with a new error, set wins.
- `cmd`=000 whenever nothing is accepted and the state is not BIN2.
- `in`=0 whenever cmd[2]=0.

## Timing
- Reset values: state=IDLE, depth=0, ovf=unf=0, t=0, opr=0. While reset is asserted, cmd=000, in=0, busy=0, op_ready=1.
- Single-cycle ops:
  - Stack effect visible on `s0` one cycle after accept.
  - Next instruction can be accepted in the next cycle; throughput is 1 per cycle.
- Binary ops:
  - Two cycles, with op_ready low in the second.
  - Result visible on `s0` two cycles after accept.
  - Throughput is 1 per 2 cycles.
- `depth` updates at the accept edge for every executed op. For binary ops that is the pop edge, not the BIN2 edge.
- Reset asserted mid-BIN2 aborts the instruction and returns all state to reset values. The stack is reset by the same reset_n.
- op_valid may stay high across BIN2; the instruction is held until op_ready returns.

## Test plan
- Add: LIT 5, LIT 3, ADD back-to-back.
  - op_ready is low exactly one cycle after ADD accept.
  - s0=8 and depth=1 two cycles after ADD accept.
  - cmd sequence is 110, 110, 001, 100.
- SUB operand order (DW=16):
  - LIT 10, LIT 3, SUB gives s0=7.
  - LIT 3, LIT 10, SUB gives s0=0xFFF9.
- Underflow:
  - DROP at reset: cmd=000, unf=1, depth=0.
  - LIT 1 then ADD: unf stays 1, s0=1, depth=1.
  - err_clr pulse: unf=0.
- Overflow with MAXD=4:
  - Four LITs give depth=4.
  - A fifth LIT gives cmd=000, ovf=1, depth=4, s0 unchanged.
  - DUP also blocked.
- DUP/NOT/XOR: LIT 0x00F0, DUP, NOT, XOR gives s0=0xFFFF, depth=1.
- Reset mid-op: LIT 2, LIT 2, ADD, with reset_n dropped during BIN2.
  - Immediately after: depth=0, busy=0, cmd=000, op_ready=1.
  - After release: LIT 7 gives s0=7.
